// File: rtl/mm_pcpi_pkg.sv
// Shared constants, FSM state and decoded-operation types for the PCPI
// matrix-multiply sequencer. Optional feature macro: MM_SEQ_PERF_EN.
package mm_pcpi_pkg;

  localparam int         N          = 3;
  localparam logic [6:0] OPCODE     = 7'b0001011;
  localparam logic [4:0] MAX_ADDR   = 5'd27;

  localparam logic [2:0] F3_WRITE   = 3'b000;
  localparam logic [2:0] F3_CLEAR   = 3'b101;
  localparam logic [2:0] F3_COMPUTE = 3'b111;
  localparam logic [2:0] F3_READ    = 3'b010;
  localparam logic [2:0] F3_PERF    = 3'b011;

  // Index of the last systolic feed step (run length is 3N-2 steps).
  localparam logic [2:0] RUN_LAST   = 3'(3 * N - 3);

  typedef enum logic [2:0] {IDLE, ACK, RUN, LATCH, GAP} state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_WRITE, OP_CLEAR, OP_COMPUTE, OP_READ, OP_PERF
  } op_t;

endpackage

// File: rtl/mm_pcpi_decode.sv
// Combinational decode of a PCPI custom-0 instruction into an operation kind
// and the operand-write fields. READ_PERF is only recognised when
// MM_SEQ_PERF_EN is defined; otherwise funct3 011 decodes as OP_NONE.
module mm_pcpi_decode
  import mm_pcpi_pkg::*;
(
  input  logic [31:0] insn,
  output op_t         op,
  output logic [4:0]  cfg_addr,
  output logic [15:0] cfg_data,
  output logic        legal
);

  // Bit 31 carries no meaning for this instruction group.
  logic unused_insn_bit;
  assign unused_insn_bit = insn[31];

  assign cfg_addr = insn[11:7];
  assign cfg_data = insn[30:15];
  assign legal    = (op != OP_NONE);

  // Map opcode + funct3 to an operation; anything unrecognised is OP_NONE.
  always_comb begin
    op = OP_NONE;
    if (insn[6:0] == OPCODE) begin
      case (insn[14:12])
        F3_WRITE:   op = OP_WRITE;
        F3_CLEAR:   op = OP_CLEAR;
        F3_COMPUTE: op = OP_COMPUTE;
        F3_READ:    op = OP_READ;
`ifdef MM_SEQ_PERF_EN
        F3_PERF:    op = OP_PERF;
`endif
        default:    op = OP_NONE;
      endcase
    end
  end

endmodule

// File: rtl/mm_pcpi_sequencer.sv
// PCPI-side sequencer for the 3x3 systolic matrix-multiply datapath.
// Optional feature macro: MM_SEQ_PERF_EN (compute/busy performance counters).
//
// state | meaning
// IDLE  | waiting for a legal custom-0 instruction
// RUN   | systolic feed in progress, PEs enabled, CPU held with wait
// LATCH | PEs idle, compare bits captured into the result register
// ACK   | one-cycle ready/wr pulse returning the response word
// GAP   | one dead cycle so a still-asserted valid is not re-accepted
module mm_pcpi_sequencer
  import mm_pcpi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        cfg_we,
  output logic [4:0]  cfg_addr,
  output logic [15:0] cfg_data,
  output logic [2:0]  feed_step,
  output logic        pe_en,
  output logic        pe_bias_sel,
  input  logic [8:0]  c_bits
);

  state_t      state, state_nxt;
  op_t         dec_op;
  logic [4:0]  dec_addr;
  logic [15:0] dec_data;
  logic        dec_legal;
  logic        accept;
  logic [2:0]  run_left;
  logic [8:0]  result;
  logic [31:0] ack_rd;

  mm_pcpi_decode u_decode (
    .insn     (pcpi_insn),
    .op       (dec_op),
    .cfg_addr (dec_addr),
    .cfg_data (dec_data),
    .legal    (dec_legal)
  );

  assign accept = (state == IDLE) && pcpi_valid && dec_legal;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nxt   = state;
    cfg_we      = 1'b0;
    pcpi_wait   = 1'b0;
    pcpi_ready  = 1'b0;
    pe_en       = 1'b0;
    pe_bias_sel = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (dec_op == OP_COMPUTE) ? RUN : ACK;
          cfg_we    = (dec_op == OP_WRITE) && (dec_addr <= MAX_ADDR);
        end
      end
      RUN: begin
        pcpi_wait   = 1'b1;
        pe_en       = 1'b1;
        pe_bias_sel = (run_left == RUN_LAST);
        if (run_left == 3'd0) state_nxt = LATCH;
      end
      LATCH: begin
        pcpi_wait = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        pcpi_ready = 1'b1;
        state_nxt  = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pcpi_wr   = pcpi_ready;
  assign pcpi_rd   = pcpi_ready ? ack_rd : 32'd0;
  assign cfg_addr  = cfg_we ? dec_addr : 5'd0;
  assign cfg_data  = cfg_we ? dec_data : 16'd0;
  // Feed index derived from the remaining-steps down-counter.
  assign feed_step = (state == RUN) ? (RUN_LAST - run_left) : 3'd0;

`ifdef MM_SEQ_PERF_EN
  logic [15:0] compute_count;
  logic [15:0] busy_cycles;

  // Completed-compute counter (saturating) and RUN+LATCH cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compute_count <= 16'd0;
      busy_cycles   <= 16'd0;
    end else if (accept && dec_op == OP_CLEAR) begin
      compute_count <= 16'd0;
      busy_cycles   <= 16'd0;
    end else begin
      if (state == LATCH && compute_count != 16'hFFFF)
        compute_count <= compute_count + 16'd1;
      if (state == RUN || state == LATCH)
        busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

  // Step down-counter, result register and the response word for ACK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_left <= 3'd0;
      result   <= 9'd0;
      ack_rd   <= 32'd0;
    end else begin
      if (accept) begin
        case (dec_op)
          OP_COMPUTE: begin
            run_left <= RUN_LAST;
            ack_rd   <= 32'd0;
          end
          OP_READ:  ack_rd <= {23'd0, result};
          OP_CLEAR: begin
            result <= 9'd0;
            ack_rd <= 32'd0;
          end
`ifdef MM_SEQ_PERF_EN
          OP_PERF:  ack_rd <= {compute_count, busy_cycles};
`endif
          default:  ack_rd <= 32'd0;
        endcase
      end
      if (state == RUN && run_left != 3'd0) run_left <= run_left - 3'd1;
      if (state == LATCH) begin
        result <= c_bits;
        ack_rd <= {23'd0, c_bits};
      end
    end
  end

endmodule

// File: tb/tb_mm_pcpi_sequencer.sv
// Self-checking bench for mm_pcpi_sequencer. Honours MM_SEQ_PERF_EN when defined.
module tb_mm_pcpi_sequencer;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = 32'd0;
  logic [8:0]  c_bits = 9'd0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, cfg_we, pe_en, pe_bias_sel;
  logic [31:0] pcpi_rd;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [2:0]  feed_step;

  int total = 0;
  int bad   = 0;

  mm_pcpi_sequencer dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .feed_step(feed_step),
    .pe_en(pe_en), .pe_bias_sel(pe_bias_sel), .c_bits(c_bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] a,
                                     input logic [15:0] d, input logic [6:0] opc);
    return {1'b0, d, f3, a, opc};
  endfunction

  function automatic bit known_f3(input logic [2:0] f);
    case (f)
      3'b000, 3'b101, 3'b111, 3'b010: return 1'b1;
`ifdef MM_SEQ_PERF_EN
      3'b011: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: outputs are a function of the cycle offset since accept.
  int          k = 0;
  logic [2:0]  m_f3 = 3'd0;
  logic [8:0]  m_res = 9'd0;
  logic [31:0] m_snap = 32'd0;
  logic [15:0] m_cc = 16'd0, m_busy = 16'd0;
  bit          acc;
  logic        e_we, e_ready, e_wait, e_pe, e_bias;
  logic [4:0]  e_addr;
  logic [15:0] e_data;
  logic [2:0]  e_step;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    e_we = 0; e_addr = 0; e_data = 0; e_ready = 0; e_wait = 0;
    e_pe = 0; e_bias = 0; e_step = 0; e_rd = 0; acc = 0;
    if (!resetn) begin
      k = 0; m_res = 0; m_cc = 0; m_busy = 0;
    end else if (k == 0) begin
      if (pcpi_valid && pcpi_insn[6:0] == OPC && known_f3(pcpi_insn[14:12])) begin
        acc  = 1;
        m_f3 = pcpi_insn[14:12];
        if (m_f3 == 3'b000 && pcpi_insn[11:7] <= 5'd27) begin
          e_we = 1; e_addr = pcpi_insn[11:7]; e_data = pcpi_insn[30:15];
        end
        case (m_f3)
          3'b101:  begin m_res = 0; m_cc = 0; m_busy = 0; m_snap = 0; end
          3'b010:  m_snap = {23'd0, m_res};
          3'b011:  m_snap = {m_cc, m_busy};
          default: m_snap = 0;
        endcase
      end
    end else if (m_f3 == 3'b111) begin
      if (k <= 7) begin e_pe = 1; e_wait = 1; e_step = 3'(k - 1); e_bias = (k == 1); end
      else if (k == 8) e_wait = 1;
      else if (k == 9) begin e_ready = 1; e_rd = m_snap; end
    end else if (k == 1) begin
      e_ready = 1; e_rd = m_snap;
    end
    check("cycle",
          {2'b0, pcpi_wr, pcpi_ready, pcpi_wait, cfg_we, pe_en, pe_bias_sel, feed_step, cfg_addr, cfg_data, pcpi_rd},
          {2'b0, e_ready, e_ready, e_wait, e_we, e_pe, e_bias, e_step, e_addr, e_data, e_rd});
    if (resetn) begin
      if (acc) k = 1;
      else if (k > 0) begin
        if (m_f3 == 3'b111 && k <= 8) m_busy = m_busy + 16'd1;
        if (m_f3 == 3'b111 && k == 8) begin
          m_res = c_bits; m_snap = {23'd0, c_bits};
          if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
        end
        if ((m_f3 == 3'b111 && k == 10) || (m_f3 != 3'b111 && k == 2)) k = 0;
        else k++;
      end
    end
  end

  // Issue one instruction, hold valid through ACK and GAP, report what was seen.
  task automatic issue(input logic [31:0] insn_v, output int lat, output int waits,
                       output logic [31:0] rd_v, output logic we_v,
                       output logic [4:0] addr_v, output logic [15:0] data_v);
    bit got;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = insn_v;
    #1; we_v = cfg_we; addr_v = cfg_addr; data_v = cfg_data;
    lat = 0; waits = 0; rd_v = 32'd0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (pcpi_ready) begin rd_v = pcpi_rd; got = 1; end
      else if (pcpi_wait) waits++;
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  task automatic ignored(input string name, input logic [31:0] insn_v);
    int hits = 0;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = insn_v;
    repeat (20) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wait || cfg_we) hits++;
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    check(name, 64'(hits), 64'd0);
  endtask

  int          lat, waits, ready_hits;
  logic [31:0] rd_v;
  logic        we_v;
  logic [4:0]  addr_v;
  logic [15:0] data_v;
  bit          hit3;

  initial begin
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {2'b0, pcpi_wr, pcpi_ready, pcpi_wait, cfg_we, pe_en, pe_bias_sel, feed_step, cfg_addr, cfg_data, pcpi_rd},
          64'd0);
    resetn = 1'b1;

    issue(mk(3'b000, 5'd5, 16'hFFF6, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("write5_we", 64'(we_v), 64'd1);
    check("write5_addr", 64'(addr_v), 64'd5);
    check("write5_data", 64'(data_v), 64'hFFF6);
    check("write5_latency", 64'(lat), 64'd1);
    check("write5_rd", 64'(rd_v), 64'd0);

    issue(mk(3'b000, 5'd30, 16'h1234, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("write30_we", 64'(we_v), 64'd0);
    check("write30_latency", 64'(lat), 64'd1);

    c_bits = 9'h1A5;
    issue(mk(3'b111, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("compute_latency", 64'(lat), 64'd9);
    check("compute_waits", 64'(waits), 64'd8);
    check("compute_rd", 64'(rd_v), 64'h1A5);
    c_bits = 9'h0F0;

    issue(mk(3'b010, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("read_after_compute", 64'(rd_v), 64'h1A5);
    issue(mk(3'b101, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("clear_rd", 64'(rd_v), 64'd0);
    issue(mk(3'b010, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("read_after_clear", 64'(rd_v), 64'd0);

    ignored("ignore_opcode", mk(3'b111, 5'd0, 16'd0, 7'b0110011));
    ignored("ignore_f3_001", mk(3'b001, 5'd3, 16'd7, OPC));
`ifndef MM_SEQ_PERF_EN
    ignored("ignore_f3_011", mk(3'b011, 5'd0, 16'd0, OPC));
`endif

    // Reset in the middle of a compute.
    c_bits = 9'h155;
    @(posedge clk); #1;
    pcpi_valid = 1'b1; pcpi_insn = mk(3'b111, 5'd0, 16'd0, OPC);
    hit3 = 0;
    for (int i = 0; i < 20 && !hit3; i++) begin
      @(posedge clk); #1;
      if (feed_step == 3'd3 && pe_en) hit3 = 1;
    end
    check("reach_step3", 64'(hit3), 64'd1);
    resetn = 1'b0; pcpi_valid = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {2'b0, pcpi_wr, pcpi_ready, pcpi_wait, cfg_we, pe_en, pe_bias_sel, feed_step, cfg_addr, cfg_data, pcpi_rd},
          64'd0);
    ready_hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (pcpi_ready) ready_hits++;
    end
    check("midrun_no_ready", 64'(ready_hits), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    issue(mk(3'b010, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("read_after_reset", 64'(rd_v), 64'd0);
    c_bits = 9'h05A;
    issue(mk(3'b111, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("compute2_latency", 64'(lat), 64'd9);
    check("compute2_rd", 64'(rd_v), 64'h05A);

`ifdef MM_SEQ_PERF_EN
    issue(mk(3'b101, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    issue(mk(3'b111, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    issue(mk(3'b111, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    issue(mk(3'b011, 5'd0, 16'd0, OPC), lat, waits, rd_v, we_v, addr_v, data_v);
    check("perf_word", 64'(rd_v), 64'h0002_0010);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
